// File: rtl/spi_master_ctrl.sv
// SPI master: serialises a 10-bit command frame on the system clock and, for
// rd-data frames, collects the 8-bit reply after a programmable turnaround.
module spi_master_ctrl #(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] cmd,
    input  logic       MISO,
    output logic       SS_n,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEL,
        S_SHIFT_CMD,
        S_TURN,
        S_SHIFT_RD,
        S_END
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [9:0] r_cmd;
    logic [7:0] r_shift;
    logic       r_is_rd;

    logic [3:0] w_next_idx;
    logic       w_frame_rd;
    logic [7:0] w_shift_in;

    // Outputs are set on the edge that enters a state, so they line up with it.
    assign w_next_idx = 4'd8 - r_cnt;
    assign w_frame_rd = (r_cmd[9:8] == 2'b11);
    assign w_shift_in = {r_shift[6:0], MISO};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_is_rd  <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cmd   <= cmd;
                        r_state <= S_START;
                        r_cnt   <= 4'd0;
                        SS_n    <= 1'b0;
                        MOSI    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_SEL;
                    r_cnt   <= 4'd0;
                    MOSI    <= r_cmd[9];
                end
                S_SEL: begin
                    r_state <= S_SHIFT_CMD;
                    r_cnt   <= 4'd0;
                    MOSI    <= r_cmd[9];
                end
                S_SHIFT_CMD: begin
                    if (r_cnt == 4'd9) begin
                        r_cnt   <= 4'd0;
                        MOSI    <= 1'b0;
                        r_is_rd <= w_frame_rd;
                        if (w_frame_rd) begin
                            r_state <= S_TURN;
                        end else begin
                            r_state <= S_END;
                            SS_n    <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        MOSI  <= r_cmd[w_next_idx];
                    end
                end
                S_TURN: begin
                    if (r_cnt == TURN_LAST) begin
                        r_state <= S_SHIFT_RD;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SHIFT_RD: begin
                    r_shift <= w_shift_in;
                    if (r_cnt == 4'd7) begin
                        r_state  <= S_END;
                        r_cnt    <= 4'd0;
                        rd_data  <= w_shift_in;
                        rd_valid <= 1'b1;
                        done     <= 1'b1;
                        SS_n     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: frame-level reference model predicts SS_n/MOSI/busy/done
// per cycle from the frame rules, plus a slave model that returns a byte on reads.
module tb_spi_master_ctrl;

    localparam int TA = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] cmd = 10'd0;
    logic       MISO = 1'b0;
    logic       SS_n, MOSI, busy, done, rd_valid;
    logic [7:0] rd_data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_done = 0;
    int         prev_done = 0;
    logic [7:0] model_rd = 8'h00;

    spi_master_ctrl #(.TURNAROUND(TA)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One frame from an IDLE cycle through END and back to IDLE.
    // Expected per-cycle signals: {SS_n, MOSI, busy, done, rd_valid}.
    task automatic run_frame(input logic [9:0] c, input logic [7:0] mb, input bit hold, input bit glitch);
        bit         rd;
        int         len;
        int         idx;
        logic       e_mosi;
        logic [4:0] obs, exp;
        rd  = (c[9:8] == 2'b11);
        len = rd ? 20 + TA : 12;
        start = 1'b1;
        cmd   = c;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 0; k < len; k++) begin
            cmd = 10'($urandom);
            if (glitch && k == 7) begin
                start = 1'b1;
                cmd   = 10'h3FF;
            end
            if (glitch && k == 8) start = hold;
            idx = 11 - k;
            if (k == 1) e_mosi = c[9];
            else if (k >= 2 && k < 12) e_mosi = c[idx];
            else e_mosi = 1'b0;
            if (rd && k >= 12 + TA) MISO = mb[7 - (k - 12 - TA)];
            else MISO = 1'($urandom);
            obs = {SS_n, MOSI, busy, done, rd_valid};
            exp = {1'b0, e_mosi, 1'b1, 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL frame_cycle cmd=%h k=%0d got %b want %b (SS_n,MOSI,busy,done,rd_valid)", c, k, obs, exp);
            end
            tick();
        end
        if (rd) model_rd = mb;
        obs = {SS_n, MOSI, busy, done, rd_valid};
        exp = {1'b1, 1'b0, 1'b1, 1'b1, rd};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL frame_end cmd=%h got %b want %b", c, obs, exp);
        end
        n_tests++;
        if (rd_data !== model_rd) begin
            n_fail++;
            $display("FAIL rd_data cmd=%h got %h want %h", c, rd_data, model_rd);
        end
        if (done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
        end
        tick();
        obs = {SS_n, MOSI, busy, done, rd_valid};
        exp = 5'b10000;
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL frame_idle cmd=%h got %b want %b", c, obs, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({SS_n, MOSI, busy, done, rd_valid, rd_data} !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset got %b %h want 10000 00", {SS_n, MOSI, busy, done, rd_valid}, rd_data);
        end
        rst = 1'b0;
        model_rd = 8'h00;
    endtask

    task automatic test_write_frame();
        run_frame(10'b00_1010_0101, 8'h00, 1'b0, 1'b0);
        run_frame(10'b01_0110_1100, 8'h00, 1'b0, 1'b0);
        run_frame(10'b10_1111_0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_read_frame();
        run_frame(10'b11_0000_0000, 8'hC3, 1'b0, 1'b0);
        run_frame(10'b00_0000_0001, 8'h00, 1'b0, 1'b0);
        run_frame(10'b11_1010_1010, 8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        int dones_before;
        dones_before = last_done;
        run_frame(10'h0F0, 8'h00, 1'b0, 1'b1);
        repeat (3) begin
            n_tests++;
            if (SS_n !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_ignored_extra_frame got SS_n=%b busy=%b want 1 0", SS_n, busy);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        cmd   = 10'b01_1100_0011;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rd = 8'h00;
        n_tests++;
        if ({SS_n, MOSI, busy, done, rd_valid, rd_data} !== {5'b10000, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset got %b %h want 10000 00", {SS_n, MOSI, busy, done, rd_valid}, rd_data);
        end
        run_frame(10'b01_0101_1010, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_done;
        run_frame(10'b01_0000_0000 | 10'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b0);
        first_done = last_done;
        run_frame(10'b01_0000_0000 | 10'($urandom_range(0, 255)), 8'h00, 1'b1, 1'b0);
        start = 1'b0;
        n_tests++;
        if (last_done - first_done !== 14) begin
            n_fail++;
            $display("FAIL back_to_back_done_spacing got %0d want 14", last_done - first_done);
        end
    endtask

    task automatic test_random();
        logic [9:0] c;
        logic [7:0] b;
        bit         h;
        for (int n = 0; n < 16; n++) begin
            c = 10'($urandom);
            b = 8'($urandom);
            h = 1'($urandom);
            run_frame(c, b, h, (n % 5) == 3);
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_frame();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
